fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the WISC pipeline. It sits between decode and execute and keeps a shift register of producer tags (valid, destination register, is-load), one per in-flight stage. Each decode-stage source register is compared against those tags, and the resulting forward select is registered into execute. It drives the execute operand muxes and the decode stall line. The unit is ISA-agnostic: the decoder resolves Rd/Rs/R7 destinations before they reach it.

---
 rtl/fwd_scoreboard_pkg.sv | 19 +
 rtl/fwd_match.sv | 35 +++
 rtl/fwd_scoreboard.sv | 117 +++++++++++
 tb/tb_fwd_scoreboard.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared WISC pipeline constants: datapath defaults and the opcodes the decoder's
// destination resolver keys on, plus the select-width helper for forwarding logic.
package fwd_scoreboard_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_SLBI = 5'b10010;

    // Select 0 is the register file, 1..depth are result positions.
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// One decode source compared against all in-flight producer tags; the youngest
// (lowest slot index) match wins and reports whether its data is still too early.
module fwd_match #(
    parameter int REG_AW   = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int SEL_W    = 2
) (
    input  logic [REG_AW-1:0]             i_src_reg,
    input  logic                          i_src_used,
    input  logic [DEPTH-1:0]              i_tag_vld,
    input  logic [DEPTH-1:0]              i_tag_ld,
    input  logic [DEPTH-1:0][REG_AW-1:0]  i_tag_reg,
    output logic [SEL_W-1:0]              o_sel,
    output logic                          o_hit,
    output logic                          o_load_haz
);

    always_comb begin
        o_sel      = '0;
        o_hit      = 1'b0;
        o_load_haz = 1'b0;
        if (i_src_used) begin
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_tag_vld[k] && (i_tag_reg[k] == i_src_reg)) begin
                    o_hit      = 1'b1;
                    o_sel      = SEL_W'(k + 1);
                    o_load_haz = i_tag_ld[k] && ((k + 1) < LOAD_RDY);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard unit between decode and execute:
// tracks producer tags per stage, stalls on early loads, registers forward selects.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_RDY = 2,
    localparam int SEL_W   = sel_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic                      id_wr_en,
    input  logic [REG_AW-1:0]         id_wr_reg,
    input  logic                      id_is_load,
    input  logic [NSRC*REG_AW-1:0]    id_src_reg,
    input  logic [NSRC-1:0]           id_src_used,
    input  logic [NSRC*DATA_W-1:0]    ex_rf_data,
    input  logic [DEPTH*DATA_W-1:0]   res_data,
    output logic                      stall,
    output logic [NSRC*DATA_W-1:0]    ex_opnd,
    output logic [NSRC*SEL_W-1:0]     ex_fwd_sel
);

    logic [DEPTH-1:0]              r_vld;
    logic [DEPTH-1:0]              r_wr;
    logic [DEPTH-1:0]              r_ld;
    logic [DEPTH-1:0][REG_AW-1:0]  r_reg;
    logic [NSRC-1:0][SEL_W-1:0]    r_sel;

    logic [NSRC-1:0][SEL_W-1:0]    w_cand;
    logic [NSRC-1:0]               w_hit;
    logic [NSRC-1:0]               w_haz;
    logic [NSRC-1:0][DATA_W-1:0]   w_opnd;
    logic                          w_stall;
    logic                          w_bubble;
    logic                          w_bad_fwd;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        fwd_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .LOAD_RDY (LOAD_RDY),
            .SEL_W    (SEL_W)
        ) u_match (
            .i_src_reg  (id_src_reg[g*REG_AW +: REG_AW]),
            .i_src_used (id_src_used[g]),
            .i_tag_vld  (r_vld & r_wr),
            .i_tag_ld   (r_ld),
            .i_tag_reg  (r_reg),
            .o_sel      (w_cand[g]),
            .o_hit      (w_hit[g]),
            .o_load_haz (w_haz[g])
        );
    end

    assign w_stall  = id_valid & ~flush & (|w_haz);
    assign w_bubble = w_stall | flush | ~id_valid;
    assign stall    = w_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            r_wr  <= '0;
            r_ld  <= '0;
            r_reg <= '0;
            r_sel <= '0;
        end else if (!pipe_hold) begin
            // Flush also kills the instruction leaving EX this edge.
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_vld[k] <= r_vld[k-1] & ~(flush && (k == 1));
                r_wr[k]  <= r_wr[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_reg[k] <= r_reg[k-1];
            end
            r_vld[0] <= ~w_bubble;
            r_wr[0]  <= id_wr_en;
            r_ld[0]  <= id_is_load;
            r_reg[0] <= id_wr_reg;
            for (int i = 0; i < NSRC; i++)
                r_sel[i] <= (w_stall | flush) ? '0 : w_cand[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_opnd[i] = ex_rf_data[i*DATA_W +: DATA_W];
            for (int j = 1; j <= DEPTH; j++)
                if (r_sel[i] == SEL_W'(j))
                    w_opnd[i] = res_data[(j-1)*DATA_W +: DATA_W];
        end
    end

    assign ex_opnd    = w_opnd;
    assign ex_fwd_sel = r_sel;

    // Position p is fed by the producer now in slot p; a load there before
    // LOAD_RDY means the stall logic let a consumer through too early.
    always_comb begin
        w_bad_fwd = 1'b0;
        for (int i = 0; i < NSRC; i++)
            for (int p = 1; p < DEPTH; p++)
                if ((r_sel[i] == SEL_W'(p)) && (p < LOAD_RDY) &&
                    r_vld[p] && r_wr[p] && r_ld[p])
                    w_bad_fwd = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!w_bad_fwd);
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: each step drives decode, checks stall at once, and queues the
// forward select/operands expected in execute after the next clock edge.
module tb_fwd_scoreboard;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int DEPTH  = 3;
    localparam int NSRC   = 2;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    pipe_hold = 1'b0;
    logic                    flush = 1'b0;
    logic                    id_valid = 1'b0;
    logic                    id_wr_en = 1'b0;
    logic [REG_AW-1:0]       id_wr_reg = '0;
    logic                    id_is_load = 1'b0;
    logic [NSRC*REG_AW-1:0]  id_src_reg = '0;
    logic [NSRC-1:0]         id_src_used = '0;
    logic [NSRC*DATA_W-1:0]  ex_rf_data = {16'h2222, 16'h1111};
    logic [DEPTH*DATA_W-1:0] res_data = {16'hDEAD, 16'h1234, 16'h00A5};
    logic                    stall;
    logic [NSRC*DATA_W-1:0]  ex_opnd;
    logic [NSRC*SEL_W-1:0]   ex_fwd_sel;

    typedef struct {
        logic [SEL_W-1:0]  sel0;
        logic [SEL_W-1:0]  sel1;
        logic [DATA_W-1:0] op0;
        logic [DATA_W-1:0] op1;
        string             tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_hold   (pipe_hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_is_load  (id_is_load),
        .id_src_reg  (id_src_reg),
        .id_src_used (id_src_used),
        .ex_rf_data  (ex_rf_data),
        .res_data    (res_data),
        .stall       (stall),
        .ex_opnd     (ex_opnd),
        .ex_fwd_sel  (ex_fwd_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One decode cycle: v/w/wr/ld describe the producer, s0/s1/used the sources.
    task automatic cyc(input string tag, input logic v, input logic w, input logic [2:0] wr,
                       input logic ld, input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] used, input logic e_stall,
                       input logic [1:0] e_sel0, input logic [1:0] e_sel1,
                       input logic [15:0] e_op0, input logic [15:0] e_op1);
        exp_t e;
        exp_t got;
        @(negedge clk);
        id_valid    = v;
        id_wr_en    = w;
        id_wr_reg   = wr;
        id_is_load  = ld;
        id_src_reg  = {s1, s0};
        id_src_used = used;
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
        e.sel0 = e_sel0; e.sel1 = e_sel1; e.op0 = e_op0; e.op1 = e_op1; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({got.tag, ".sel0"}, 32'(ex_fwd_sel[1:0]), 32'(got.sel0));
        chk({got.tag, ".sel1"}, 32'(ex_fwd_sel[3:2]), 32'(got.sel1));
        chk({got.tag, ".op0"},  32'(ex_opnd[15:0]),   32'(got.op0));
        chk({got.tag, ".op1"},  32'(ex_opnd[31:16]),  32'(got.op1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: decode invalid so stall is defined before state clears
        rst = 1'b0;
        cyc("rst0", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        rst = 1'b1;

        // add r3 ; add using r3
        cyc("add_r3",  1, 1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        cyc("use_r3",  1, 1, 5, 0, 3, 0, 2'b01, 0, 1, 0, 16'h00A5, 16'h2222);

        // ld r2 ; add using r2 -> one stall cycle, then sel 2
        cyc("ld_r2",   1, 1, 2, 1, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        cyc("lu_stl",  1, 1, 6, 0, 2, 0, 2'b01, 1, 0, 0, 16'h1111, 16'h2222);
        cyc("lu_go",   1, 1, 6, 0, 2, 0, 2'b01, 0, 2, 0, 16'h1234, 16'h2222);

        // two r4 producers: youngest wins on both channels
        cyc("r4_a",    1, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        cyc("r4_b",    1, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        cyc("use_r4",  1, 1, 7, 0, 4, 4, 2'b11, 0, 1, 1, 16'h00A5, 16'h00A5);

        // r7 from jal ages through every position, then out to the register file
        cyc("r7_p1",   1, 0, 0, 0, 0, 7, 2'b10, 0, 0, 1, 16'h1111, 16'h00A5);
        cyc("r7_p2",   1, 0, 0, 0, 0, 7, 2'b10, 0, 0, 2, 16'h1111, 16'h1234);
        cyc("r7_p3",   1, 0, 0, 0, 0, 7, 2'b10, 0, 0, 3, 16'h1111, 16'hDEAD);
        cyc("r7_old",  1, 0, 0, 0, 7, 0, 2'b01, 0, 0, 0, 16'h1111, 16'h2222);

        // flush on a pending load-use: no stall, EX and MEM slots squashed
        cyc("ld_r1",   1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        flush = 1'b1;
        cyc("flush",   1, 1, 3, 0, 1, 0, 2'b01, 0, 0, 0, 16'h1111, 16'h2222);
        flush = 1'b0;
        cyc("post_fl", 1, 1, 5, 0, 1, 3, 2'b11, 0, 0, 0, 16'h1111, 16'h2222);

        // pipe_hold during a load-use stall freezes everything
        cyc("ld_r2b",  1, 1, 2, 1, 5, 0, 2'b01, 0, 1, 0, 16'h00A5, 16'h2222);
        pipe_hold = 1'b1;
        for (int n = 0; n < 4; n++)
            cyc("hold",  1, 1, 6, 0, 2, 0, 2'b01, 1, 1, 0, 16'h00A5, 16'h2222);
        pipe_hold = 1'b0;
        cyc("rel_stl", 1, 1, 6, 0, 2, 0, 2'b01, 1, 0, 0, 16'h1111, 16'h2222);
        cyc("rel_go",  1, 1, 6, 0, 2, 0, 2'b01, 0, 2, 0, 16'h1234, 16'h2222);

        // reset mid-stall clears tags so the held consumer goes straight through
        cyc("ld_r3",   1, 1, 3, 1, 0, 0, 2'b00, 0, 0, 0, 16'h1111, 16'h2222);
        rst = 1'b0;
        cyc("rst_stl", 1, 1, 6, 0, 3, 0, 2'b01, 1, 0, 0, 16'h1111, 16'h2222);
        rst = 1'b1;
        cyc("rst_go",  1, 1, 6, 0, 3, 0, 2'b01, 0, 0, 0, 16'h1111, 16'h2222);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_empty: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
